insn_fetch_ctrl: RTL and testbench

INSN_FETCH_CTRL -- requirements
Module: insn_fetch_ctrl

---
 rtl/insn_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_insn_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_ctrl.sv
// insn_fetch_ctrl: instruction fetch sequencer (IDLE/FETCH/HALTED) driving a combinational ROM.
// Define INSN_FETCH_COUNT_EN to enable the issued-instruction counter on insn_count.
module insn_fetch_ctrl #(
  parameter int IW = 16
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [IW-1:0] start_addr,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [IW-1:0] branch_target,
  input  logic          halt_req,
  output logic [IW-1:0] insn_addr,
  input  logic [8:0]    rom_data,
  output logic [8:0]    insn_out,
  output logic          insn_valid,
  output logic          done,
  output logic [31:0]   insn_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] pc, pc_nx;
  logic [8:0]    insn_q, insn_nx;
  logic          valid_q, valid_nx;
  logic          issue;
  logic          start_acc;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx  = state;
    pc_nx     = pc;
    insn_nx   = insn_q;
    valid_nx  = valid_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    unique case (state)
      FETCH: begin
        if (halt_req) begin
          state_nx = HALTED;
          valid_nx = 1'b0;
        end else if (branch_en) begin
          pc_nx    = branch_rel ? pc + branch_target : branch_target;
          valid_nx = 1'b0;
        end else if (!stall) begin
          issue    = 1'b1;
          insn_nx  = rom_data;
          valid_nx = 1'b1;
          pc_nx    = pc + IW'(1);
          // The last ROM word is still issued; its valid flag drops on the first HALTED edge.
          if (pc == {IW{1'b1}}) state_nx = HALTED;
        end
      end
      default: begin
        valid_nx = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          pc_nx     = start_addr;
          state_nx  = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Reset_n) begin
      state   <= IDLE;
      pc      <= '0;
      insn_q  <= 9'h000;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      insn_q  <= insn_nx;
      valid_q <= valid_nx;
    end
  end

`ifdef INSN_FETCH_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)      count_q <= '0;
    else if (start_acc) count_q <= '0;
    else if (issue)    count_q <= count_q + 32'd1;
  end

  assign insn_count = count_q;
`else
  logic unused_cnt;
  assign unused_cnt = issue ^ start_acc;
  assign insn_count = 32'd0;
`endif

  assign insn_addr  = pc;
  assign insn_out   = insn_q;
  assign insn_valid = valid_q;
  assign done       = (state == HALTED);

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Scoreboard bench for insn_fetch_ctrl: directed scenarios plus randomized stimulus
// checked every cycle against a rule-level reference model.
module tb_insn_fetch_ctrl;
  localparam int IW = 16;
  localparam logic [IW-1:0] PC_MAX = '1;
`ifdef INSN_FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0, stall = 1'b0, branch_en = 1'b0, branch_rel = 1'b0, halt_req = 1'b0;
  logic [IW-1:0] start_addr = '0, branch_target = '0;
  logic [IW-1:0] insn_addr;
  logic [8:0]    rom_data, insn_out;
  logic          insn_valid, done;
  logic [31:0]   insn_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IW-1:0] addr;
    logic [8:0]    insn;
    logic          valid;
    logic          done;
    logic [31:0]   count;
  } snap_t;

  snap_t exp_q[$];
  bit    armed = 1'b0;

  // Reference model: running/halted flags, program counter, last issued word, issue count.
  bit            m_run, m_halted, m_live;
  logic [IW-1:0] m_pc;
  logic [8:0]    m_insn;
  logic [31:0]   m_count;

  insn_fetch_ctrl #(.IW(IW)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .halt_req(halt_req), .insn_addr(insn_addr),
    .rom_data(rom_data), .insn_out(insn_out), .insn_valid(insn_valid),
    .done(done), .insn_count(insn_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] rom(input logic [IW-1:0] a);
    logic [IW-1:0] t;
    t = (a * 16'd7) ^ (a >> 5);
    return t[8:0] ^ 9'h0a5;
  endfunction

  assign rom_data = rom(insn_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Applies the fetch rules for one clock edge to the model, using the current inputs.
  task automatic model_edge;
    if (!m_run) begin
      m_live = 1'b0;
      if (start) begin
        m_pc = start_addr; m_run = 1'b1; m_halted = 1'b0; m_count = 0;
      end
    end else if (halt_req) begin
      m_run = 1'b0; m_halted = 1'b1; m_live = 1'b0;
    end else if (branch_en) begin
      m_pc   = branch_rel ? m_pc + branch_target : branch_target;
      m_live = 1'b0;
    end else if (!stall) begin
      m_insn  = rom(m_pc);
      m_live  = 1'b1;
      m_count = m_count + 1;
      if (m_pc == PC_MAX) begin
        m_run = 1'b0; m_halted = 1'b1;
      end
      m_pc = m_pc + 1'b1;
    end
  endtask

  task automatic push_expect;
    snap_t s;
    s.addr  = m_pc;
    s.insn  = m_insn;
    s.valid = m_live;
    s.done  = m_halted;
    s.count = CNT_EN ? m_count : 32'd0;
    exp_q.push_back(s);
    armed = 1'b1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input logic [IW-1:0] sa, input bit st, input bit br,
                      input bit rel, input logic [IW-1:0] tgt, input bit h);
    start = s; start_addr = sa; stall = st; branch_en = br;
    branch_rel = rel; branch_target = tgt; halt_req = h;
    model_edge();
    push_expect();
    @(negedge CLK);
  endtask

  task automatic free_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset;
    #2;
    Reset_n = 1'b0;
    start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_rel = 1'b0; halt_req = 1'b0;
    #1;
    check("rst_addr",  32'(insn_addr), 32'h0);
    check("rst_insn",  32'(insn_out), 32'h0);
    check("rst_valid", 32'(insn_valid), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    check("rst_count", insn_count, 32'h0);
    m_run = 1'b0; m_halted = 1'b0; m_live = 1'b0; m_pc = '0; m_insn = '0; m_count = 0;
    push_expect();
    @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the oldest expectation one step after each rising edge.
  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underrun actual=empty required=entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("mon_addr",  32'(insn_addr), 32'(e.addr));
          check("mon_insn",  32'(insn_out), 32'(e.insn));
          check("mon_valid", 32'(insn_valid), 32'(e.valid));
          check("mon_done",  32'(done), 32'(e.done));
          check("mon_count", insn_count, e.count);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [IW-1:0] sa, tgt;
    bit rel;
    @(negedge CLK);
    do_reset();

    // Straight-line fetch from 0x10.
    step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("start_addr", 32'(insn_addr), 32'h10);
    check("start_valid", 32'(insn_valid), 32'h0);
    free_steps(4);
    check("seq_addr", 32'(insn_addr), 32'h14);
    check("seq_insn", 32'(insn_out), 32'(rom(16'h0013)));

    // Relative branch backwards by 2 from 0x20.
    do_reset();
    step(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    check("brel_addr", 32'(insn_addr), 32'h1E);
    check("brel_valid", 32'(insn_valid), 32'h0);
    free_steps(1);
    check("brel_insn", 32'(insn_out), 32'(rom(16'h001E)));
    check("brel_valid2", 32'(insn_valid), 32'h1);

    // Halt wins over branch and stall; then restart at 0.
    do_reset();
    step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'h0033, 1'b1);
    check("halt_done", 32'(done), 32'h1);
    check("halt_addr", 32'(insn_addr), 32'h5);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("restart_addr", 32'(insn_addr), 32'h0);
    check("restart_done", 32'(done), 32'h0);
    free_steps(2);

    // Three-cycle stall at 0x08 with a live instruction.
    do_reset();
    step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    free_steps(1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("stall_addr", 32'(insn_addr), 32'h8);
    check("stall_insn", 32'(insn_out), 32'(rom(16'h0007)));
    check("stall_valid", 32'(insn_valid), 32'h1);
    free_steps(1);
    check("unstall_addr", 32'(insn_addr), 32'h9);

    // End-of-ROM wrap: last two words issued, then halted at PC 0.
    do_reset();
    step(1'b1, PC_MAX - 16'd1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    free_steps(2);
    check("wrap_addr", 32'(insn_addr), 32'h0);
    check("wrap_done", 32'(done), 32'h1);
    check("wrap_insn", 32'(insn_out), 32'(rom(PC_MAX)));
    check("wrap_count", insn_count, CNT_EN ? 32'd2 : 32'd0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'h0044, 1'b1);
    check("halted_valid", 32'(insn_valid), 32'h0);
    check("halted_addr", 32'(insn_addr), 32'h0);

    // Asynchronous reset in the middle of fetching.
    step(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    free_steps(2);
    do_reset();
    free_steps(2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      sa  = ($urandom_range(0, 2) == 0) ? PC_MAX - 16'($urandom_range(0, 6)) : 16'($urandom);
      rel = 1'($urandom_range(0, 1));
      tgt = rel ? 16'($urandom_range(0, 16)) - 16'd8 : 16'($urandom);
      step($urandom_range(0, 5) == 0, sa, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, rel, tgt, $urandom_range(0, 29) == 0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
